// File: rtl/ram_responder.sv
// Memory-side responder: DEPTH x DATA_WIDTH word RAM with a wait-state access FSM and memDone handshake.
// Optional write protection of the top address range is enabled by defining RAM_WPROT_EN.
module ram_responder #(
  parameter int                    ADDR_WIDTH   = 9,
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    DEPTH        = 512,
  parameter int                    WAIT_STATES  = 2,
  parameter logic [ADDR_WIDTH-1:0] PROTECT_BASE = 9'h1F0
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Read,
  input  logic                  Write,
  input  logic [ADDR_WIDTH-1:0] marToRam,
  input  logic [DATA_WIDTH-1:0] mdrToRam,
  output logic [DATA_WIDTH-1:0] ramToMdr,
  output logic                  memBusy,
  output logic                  memDone,
  output logic                  memErr
);

`ifdef RAM_WPROT_EN
  localparam logic WPROT_EN = 1'b1;
`else
  localparam logic WPROT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DONE    = 2'd2,
    S_RELEASE = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    wr_q, wr_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    finish_s;
  logic                    protect_s;
  logic                    mem_we_s;
  logic [ADDR_WIDTH-1:0]   acc_addr_s;
  logic [DATA_WIDTH-1:0]   acc_data_s;
  logic                    acc_wr_s;

  // Next-state, capture and completion logic for the access FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    wr_d       = wr_q;
    rdata_d    = rdata_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    finish_s   = 1'b0;
    protect_s  = 1'b0;
    mem_we_s   = 1'b0;
    acc_addr_s = addr_q;
    acc_data_s = data_q;
    acc_wr_s   = wr_q;

    case (state_q)
      S_IDLE: begin
        if (Read || Write) begin
          addr_d     = marToRam;
          data_d     = mdrToRam;
          wr_d       = Write;
          // With zero wait states the access completes on the capture edge itself.
          acc_addr_s = marToRam;
          acc_data_s = mdrToRam;
          acc_wr_s   = Write;
          if (WAIT_STATES == 0) begin
            state_d  = S_DONE;
            finish_s = 1'b1;
          end else begin
            state_d  = S_WAIT;
            cnt_d    = 4'(WAIT_STATES);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d  = S_DONE;
          cnt_d    = 4'd0;
          finish_s = 1'b1;
        end else begin
          state_d  = S_WAIT;
          cnt_d    = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (!Read && !Write) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RELEASE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (finish_s) begin
      protect_s = WPROT_EN && acc_wr_s && (acc_addr_s >= PROTECT_BASE);
      done_d    = 1'b1;
      err_d     = protect_s;
      if (acc_wr_s) begin
        mem_we_s = !protect_s;
      end else begin
        rdata_d  = mem_q[acc_addr_s];
      end
    end else begin
      protect_s = 1'b0;
    end

    busy_d = (state_d == S_WAIT) || (state_d == S_DONE);
  end

  // FSM and output registers; reset aborts any access in flight.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // RAM array: contents survive reset, but a write completing under reset is dropped.
  always_ff @(posedge Clock) begin
    if (mem_we_s && !Reset) begin
      mem_q[acc_addr_s] <= acc_data_s;
    end
  end

  assign ramToMdr = rdata_q;
  assign memBusy  = busy_q;
  assign memDone  = done_q;
  assign memErr   = err_q;

endmodule

// File: tb/tb_ram_responder.sv
// Self-checking bench for ram_responder: directed handshake scenarios plus randomized accesses
// scored against an array model of the RAM and a cycle-count model of the handshake.
module tb_ram_responder;
  localparam int AW = 9;
  localparam int DW = 32;
  localparam int WS = 2;
  localparam logic [AW-1:0] PBASE = 9'h1F0;
`ifdef RAM_WPROT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic          Clock = 1'b0;
  logic          Reset;
  logic          Read;
  logic          Write;
  logic [AW-1:0] marToRam;
  logic [DW-1:0] mdrToRam;
  logic [DW-1:0] ramToMdr;
  logic          memBusy;
  logic          memDone;
  logic          memErr;

  int nchk = 0;
  int nerr = 0;

  logic [DW-1:0] ref_mem [512];
  bit            known   [512];
  logic [AW-1:0] known_q [$];
  logic [DW-1:0] last_rd;

  always #5 Clock = ~Clock;

  ram_responder #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .DEPTH       (512),
    .WAIT_STATES (WS),
    .PROTECT_BASE(PBASE)
  ) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Read    (Read),
    .Write   (Write),
    .marToRam(marToRam),
    .mdrToRam(mdrToRam),
    .ramToMdr(ramToMdr),
    .memBusy (memBusy),
    .memDone (memDone),
    .memErr  (memErr)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete access: request, WS wait cycles, DONE, RELEASE, back to idle.
  task automatic access(input bit rd, input bit wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input string tag);
    bit            prot;
    logic [DW-1:0] exp_rd;
    prot   = PROT && wr && (a >= PBASE);
    exp_rd = ref_mem[a];
    @(negedge Clock);
    Read = rd; Write = wr; marToRam = a; mdrToRam = d;
    @(posedge Clock);
    for (int c = 1; c <= WS + 1; c++) begin
      @(negedge Clock);
      check({tag, " busy"}, 32'(memBusy), 32'd1);
      check({tag, " done"}, 32'(memDone), (c == WS + 1) ? 32'd1 : 32'd0);
      check({tag, " err"},  32'(memErr),  (c == WS + 1 && prot) ? 32'd1 : 32'd0);
      if (c == WS + 1 && !wr) begin
        check({tag, " rdata"}, ramToMdr, exp_rd);
        last_rd = exp_rd;
      end else begin
        check({tag, " rdata hold"}, ramToMdr, last_rd);
      end
      if (c < WS + 1) begin
        marToRam = AW'($urandom);
        mdrToRam = $urandom;
      end
    end
    if (wr && !prot) begin
      ref_mem[a] = d;
      if (!known[a]) known_q.push_back(a);
      known[a] = 1'b1;
    end
    @(negedge Clock);
    check({tag, " release busy"}, 32'(memBusy), 32'd0);
    check({tag, " release done"}, 32'(memDone), 32'd0);
    check({tag, " release rdata"}, ramToMdr, last_rd);
    Read = 1'b0; Write = 1'b0;
    @(negedge Clock);
    check({tag, " idle busy"}, 32'(memBusy), 32'd0);
  endtask

  initial begin
    int            pulses;
    int            op;
    logic [AW-1:0] ra;
    logic [DW-1:0] v;

    Reset = 1'b1; Read = 1'b0; Write = 1'b0; marToRam = '0; mdrToRam = '0;
    last_rd = '0;
    repeat (2) @(negedge Clock);
    check("reset rdata", ramToMdr, 32'd0);
    check("reset busy", 32'(memBusy), 32'd0);
    check("reset done", 32'(memDone), 32'd0);
    check("reset err", 32'(memErr), 32'd0);
    Reset = 1'b0;
    @(negedge Clock);

    access(1'b0, 1'b1, 9'h010, 32'hDEADBEEF, "t1 write");
    access(1'b1, 1'b0, 9'h010, 32'h0, "t2 read");

    // Held strobe must produce a single completion until it is dropped.
    @(negedge Clock);
    Read = 1'b1; marToRam = 9'h010;
    pulses = 0;
    repeat (12) begin
      @(negedge Clock);
      if (memDone) pulses++;
    end
    check("t3 held one pulse", 32'(pulses), 32'd1);
    check("t3 held rdata", ramToMdr, 32'hDEADBEEF);
    Read = 1'b0;
    @(negedge Clock);
    Read = 1'b1;
    repeat (6) begin
      @(negedge Clock);
      if (memDone) pulses++;
    end
    check("t3 re-raise pulse", 32'(pulses), 32'd2);
    Read = 1'b0;
    repeat (2) @(negedge Clock);

    access(1'b1, 1'b1, 9'h020, 32'h00001234, "t4 both");
    access(1'b1, 1'b0, 9'h020, 32'h0, "t4 read");
    check("t4 rdata", ramToMdr, 32'h00001234);

    // Reset during WAIT must abort the write.
    access(1'b0, 1'b1, 9'h030, 32'h0BADF00D, "t5 prior");
    @(negedge Clock);
    Write = 1'b1; marToRam = 9'h030; mdrToRam = 32'hAAAA5555;
    @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b1; Write = 1'b0;
    @(negedge Clock);
    check("t5 reset busy", 32'(memBusy), 32'd0);
    check("t5 reset done", 32'(memDone), 32'd0);
    check("t5 reset rdata", ramToMdr, 32'd0);
    check("t5 reset err", 32'(memErr), 32'd0);
    Reset = 1'b0;
    last_rd = '0;
    @(negedge Clock);
    access(1'b1, 1'b0, 9'h030, 32'h0, "t5 read");
    check("t5 prior kept", ramToMdr, 32'h0BADF00D);

`ifdef RAM_WPROT_EN
    access(1'b1, 1'b0, 9'h1F5, 32'h0, "t6 pre-read");
    v = ramToMdr;
    ref_mem[9'h1F5] = v;
    known[9'h1F5] = 1'b1;
    known_q.push_back(9'h1F5);
    access(1'b0, 1'b1, 9'h1F5, 32'hFFFFFFFF, "t6 prot write");
    access(1'b1, 1'b0, 9'h1F5, 32'h0, "t6 prot read");
    check("t6 old value", ramToMdr, v);
    access(1'b0, 1'b1, 9'h1EF, 32'h5A5A0001, "t6 ok write");
    access(1'b1, 1'b0, 9'h1EF, 32'h0, "t6 ok read");
`endif

    for (int i = 0; i < 30; i++) begin
      op = int'($urandom_range(0, 2));
      ra = AW'($urandom);
      v  = $urandom;
      if (op == 1 && known_q.size() > 0) begin
        ra = known_q[$urandom_range(0, known_q.size() - 1)];
        access(1'b1, 1'b0, ra, v, "rand read");
      end else if (op == 2) begin
        access(1'b1, 1'b1, ra, v, "rand both");
      end else begin
        access(1'b0, 1'b1, ra, v, "rand write");
      end
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
